// File: rtl/div_ctrl_pkg.sv
// Shared constants for the div_pipe scheduler: pipe latency, credit counter
// width and the layout of the per-request metadata word.
// With DIV_SIGNED_EN defined, the metadata also carries two sign bits.
package div_ctrl_pkg;

`ifdef DIV_SIGNED_EN
  localparam int SIGN_W    = 2;
  localparam int NEG_R_BIT = 0;  // remainder takes the dividend's sign
  localparam int NEG_Q_BIT = 1;  // quotient negated when operand signs differ
`else
  localparam int SIGN_W    = 0;
`endif
  localparam int DZ_BIT    = SIGN_W;
  localparam int TAG_LSB   = SIGN_W + 1;

  // Register stages inside div_pipe.
  function automatic int div_latency(input int data_w, input int opers_per_stage);
    return data_w / opers_per_stage;
  endfunction

  // Metadata word: {tag, dz, [neg_q, neg_r]}.
  function automatic int meta_width(input int tag_w);
    return tag_w + 1 + SIGN_W;
  endfunction

  // Counter able to hold 0..depth outstanding requests.
  function automatic int credit_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/div_ctrl_fifo.sv
// Synchronous first-word-fall-through FIFO. The head entry is always
// presented on rdata; a push into an empty FIFO is visible the next cycle.
module div_ctrl_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             empty
);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             wr_s, rd_s;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    if (p == PTR_W'(DEPTH - 1)) begin
      return '0;
    end else begin
      return p + PTR_W'(1);
    end
  endfunction

  // Pointer and occupancy update; a push while full is taken only alongside a pop.
  always_comb begin
    rd_s     = pop && (cnt_q != '0);
    wr_s     = push && ((cnt_q != CNT_W'(DEPTH)) || rd_s);
    wr_ptr_d = wr_s ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d = rd_s ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    case ({wr_s, rd_s})
      2'b10:   cnt_d = cnt_q + CNT_W'(1);
      2'b01:   cnt_d = cnt_q - CNT_W'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  // Control state; reset empties the FIFO.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Storage array; contents are only meaningful under the occupancy count.
  always_ff @(posedge clk) begin
    if (wr_s) begin
      mem_q[wr_ptr_q] <= wdata;
    end
  end

  assign rdata = mem_q[rd_ptr_q];
  assign empty = (cnt_q == '0);

endmodule

// File: rtl/div_pipe.sv
// Free-running pipelined restoring divider: DATA_W/OPERS_PER_STAGE register
// stages, each retiring OPERS_PER_STAGE quotient bits. No valid or stall.
// Requires at least two stages.
module div_pipe #(
  parameter int DATA_W          = 32,
  parameter int OPERS_PER_STAGE = 8
) (
  input  logic              clk,
  input  logic [DATA_W-1:0] dividend,
  input  logic [DATA_W-1:0] divisor,
  output logic [DATA_W-1:0] quotient,
  output logic [DATA_W-1:0] remainder
);
  localparam int L = DATA_W / OPERS_PER_STAGE;

  logic [L-1:0][DATA_W-1:0] rem_q, rem_d, acc_q, acc_d;
  logic [L-2:0][DATA_W-1:0] dsr_q, dsr_d;

  // OPERS_PER_STAGE restoring steps; quotient bits shift into acc's LSB.
  function automatic logic [2*DATA_W-1:0] div_step(input logic [DATA_W-1:0] rem_i,
                                                   input logic [DATA_W-1:0] acc_i,
                                                   input logic [DATA_W-1:0] dsr);
    logic [DATA_W:0]   r;
    logic [DATA_W-1:0] a;
    r = {1'b0, rem_i};
    a = acc_i;
    for (int k = 0; k < OPERS_PER_STAGE; k++) begin
      r = {r[DATA_W-1:0], a[DATA_W-1]};
      a = {a[DATA_W-2:0], 1'b0};
      if (r >= {1'b0, dsr}) begin
        r    = r - {1'b0, dsr};
        a[0] = 1'b1;
      end else begin
        a[0] = 1'b0;
      end
    end
    return {r[DATA_W-1:0], a};
  endfunction

  // Stage s consumes stage s-1's partial remainder, shifted dividend and divisor.
  always_comb begin
    {rem_d[0], acc_d[0]} = div_step('0, dividend, divisor);
    dsr_d[0] = divisor;
    for (int s = 1; s < L; s++) begin
      {rem_d[s], acc_d[s]} = div_step(rem_q[s-1], acc_q[s-1], dsr_q[s-1]);
    end
    for (int s = 1; s < L - 1; s++) begin
      dsr_d[s] = dsr_q[s-1];
    end
  end

  // Pure datapath registers; validity is tracked by the scheduler.
  always_ff @(posedge clk) begin
    rem_q <= rem_d;
    acc_q <= acc_d;
    dsr_q <= dsr_d;
  end

  assign quotient  = acc_q[L-1];
  assign remainder = rem_q[L-1];

endmodule

// File: rtl/div_pipe_ctrl.sv
// Valid/ready scheduler around div_pipe. Requests are tracked through the
// fixed pipe latency by a valid/metadata shift register; results land in an
// FWFT FIFO whose space is reserved by a credit counter at accept time, so the
// free-running pipe never needs to stall. Optional macro DIV_SIGNED_EN adds
// signed operation selected per request by in_signed.
module div_pipe_ctrl
  import div_ctrl_pkg::*;
#(
  parameter int DATA_W          = 32,
  parameter int OPERS_PER_STAGE = 8,
  parameter int TAG_W           = 4,
  parameter int FIFO_DEPTH      = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_dividend,
  input  logic [DATA_W-1:0] in_divisor,
  input  logic [TAG_W-1:0]  in_tag,
  input  logic              in_signed,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_quotient,
  output logic [DATA_W-1:0] out_remainder,
  output logic [TAG_W-1:0]  out_tag,
  output logic              out_div_by_zero,
  output logic              busy
);
  localparam int L     = div_latency(DATA_W, OPERS_PER_STAGE);
  localparam int MW    = meta_width(TAG_W);
  localparam int CNT_W = credit_width(FIFO_DEPTH);
  localparam int FW    = 2 * DATA_W + TAG_W + 1;

  logic                     acc_s, pop_s, empty_s;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic                     in_ready_q, in_ready_d, busy_q, busy_d;
  logic [DATA_W-1:0]        op_a_q, op_a_d, op_b_q, op_b_d;
  logic [L:0]               vld_q, vld_d;
  logic [L:0][MW-1:0]       meta_q, meta_d;
  logic [L:0][DATA_W-1:0]   dvd_q, dvd_d;
  logic [MW-1:0]            entry_s;
  logic [DATA_W-1:0]        a_s, b_s, pipe_q_s, pipe_r_s, fix_q_s, fix_r_s;
  logic [FW-1:0]            wdata_s, rdata_s;
`ifdef DIV_SIGNED_EN
  logic                     neg_a_s, neg_b_s;
`else
  logic                     unused_signed_s;
  assign unused_signed_s = in_signed;
`endif

  assign acc_s = in_valid && in_ready_q;
  assign pop_s = !empty_s && out_ready;

  // Operand conditioning, tracking shift register and credit accounting.
  always_comb begin
    entry_s = '0;
`ifdef DIV_SIGNED_EN
    neg_a_s = in_signed && in_dividend[DATA_W-1];
    neg_b_s = in_signed && in_divisor[DATA_W-1];
    a_s     = neg_a_s ? -in_dividend : in_dividend;
    b_s     = neg_b_s ? -in_divisor : in_divisor;
    entry_s[NEG_Q_BIT] = neg_a_s ^ neg_b_s;
    entry_s[NEG_R_BIT] = neg_a_s;
`else
    a_s     = in_dividend;
    b_s     = in_divisor;
`endif
    entry_s[DZ_BIT]                = (in_divisor == '0);
    entry_s[TAG_LSB +: TAG_W]      = in_tag;
    if (acc_s) begin
      op_a_d = a_s;
      op_b_d = b_s;
    end else begin
      op_a_d = op_a_q;
      op_b_d = op_b_q;
    end
    vld_d  = {vld_q[L-1:0], acc_s};
    meta_d = {meta_q[L-1:0], entry_s};
    dvd_d  = {dvd_q[L-1:0], in_dividend};
    case ({acc_s, pop_s})
      2'b10:   cnt_d = cnt_q + CNT_W'(1);
      2'b01:   cnt_d = cnt_q - CNT_W'(1);
      default: cnt_d = cnt_q;
    endcase
    in_ready_d = (cnt_d < CNT_W'(FIFO_DEPTH));
    busy_d     = (cnt_d != '0);
  end

  // All scheduler state; reset drops every in-flight request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q      <= '0;
      in_ready_q <= 1'b0;
      busy_q     <= 1'b0;
      op_a_q     <= '0;
      op_b_q     <= '0;
      vld_q      <= '0;
      meta_q     <= '0;
      dvd_q      <= '0;
    end else begin
      cnt_q      <= cnt_d;
      in_ready_q <= in_ready_d;
      busy_q     <= busy_d;
      op_a_q     <= op_a_d;
      op_b_q     <= op_b_d;
      vld_q      <= vld_d;
      meta_q     <= meta_d;
      dvd_q      <= dvd_d;
    end
  end

  div_pipe #(
    .DATA_W          (DATA_W),
    .OPERS_PER_STAGE (OPERS_PER_STAGE)
  ) u_div_pipe (
    .clk       (clk),
    .dividend  (op_a_q),
    .divisor   (op_b_q),
    .quotient  (pipe_q_s),
    .remainder (pipe_r_s)
  );

  // Result fixup at the pipe tail: divide-by-zero override, then sign restore.
  always_comb begin
    if (meta_q[L][DZ_BIT]) begin
      fix_q_s = '1;
      fix_r_s = dvd_q[L];
    end else begin
`ifdef DIV_SIGNED_EN
      fix_q_s = meta_q[L][NEG_Q_BIT] ? -pipe_q_s : pipe_q_s;
      fix_r_s = meta_q[L][NEG_R_BIT] ? -pipe_r_s : pipe_r_s;
`else
      fix_q_s = pipe_q_s;
      fix_r_s = pipe_r_s;
`endif
    end
    wdata_s = {fix_q_s, fix_r_s, meta_q[L][TAG_LSB +: TAG_W], meta_q[L][DZ_BIT]};
  end

  div_ctrl_fifo #(
    .WIDTH (FW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (vld_q[L]),
    .wdata (wdata_s),
    .pop   (pop_s),
    .rdata (rdata_s),
    .empty (empty_s)
  );

  // Head entry drives the outputs; zero whenever nothing is buffered.
  always_comb begin
    if (empty_s) begin
      out_quotient    = '0;
      out_remainder   = '0;
      out_tag         = '0;
      out_div_by_zero = 1'b0;
    end else begin
      {out_quotient, out_remainder, out_tag, out_div_by_zero} = rdata_s;
    end
  end

  assign out_valid = !empty_s;
  assign in_ready  = in_ready_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_div_pipe_ctrl.sv
// Scoreboard bench for div_pipe_ctrl: stimulus pushes hand-computed results,
// a monitor thread pops and compares on every output handshake.
module tb_div_pipe_ctrl;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready, in_signed, out_valid, out_ready;
  logic [31:0] in_dividend, in_divisor, out_quotient, out_remainder;
  logic [3:0]  in_tag, out_tag;
  logic        out_div_by_zero, busy;

  typedef struct packed {
    logic [31:0] q;
    logic [31:0] r;
    logic [3:0]  tag;
    logic        dz;
    logic        lat;
    int          acc;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;

  logic [31:0] b2b_a [8] = '{32'd1000, 32'd255, 32'hFFFF_FFFF, 32'd5,
                             32'hDEAD_BEEF, 32'd81, 32'd12345, 32'h8000_0000};
  logic [31:0] b2b_b [8] = '{32'd10, 32'd16, 32'd1, 32'd9, 32'h0001_0000, 32'd9, 32'd0, 32'd3};
  logic [31:0] b2b_q [8] = '{32'd100, 32'd15, 32'hFFFF_FFFF, 32'd0,
                             32'h0000_DEAD, 32'd9, 32'hFFFF_FFFF, 32'h2AAA_AAAA};
  logic [31:0] b2b_r [8] = '{32'd0, 32'd15, 32'd0, 32'd5, 32'h0000_BEEF, 32'd0, 32'd12345, 32'd2};
  logic        b2b_z [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};

  logic [31:0] bp_a [10] = '{32'd10, 32'd20, 32'd30, 32'd40, 32'd50,
                             32'd60, 32'd70, 32'd80, 32'd90, 32'd100};
  logic [31:0] bp_b [10] = '{32'd3, 32'd3, 32'd4, 32'd6, 32'd7, 32'd8, 32'd9, 32'd11, 32'd13, 32'd0};
  logic [31:0] bp_q [10] = '{32'd3, 32'd6, 32'd7, 32'd6, 32'd7, 32'd7, 32'd7, 32'd7, 32'd6, 32'hFFFF_FFFF};
  logic [31:0] bp_r [10] = '{32'd1, 32'd2, 32'd2, 32'd4, 32'd1, 32'd4, 32'd7, 32'd3, 32'd12, 32'd100};

  logic [31:0] sg_a [5] = '{32'hFFFF_FFF9, 32'd7, 32'h8000_0000, 32'hFFFF_FFFB, 32'hFFFF_FFF9};
  logic [31:0] sg_b [5] = '{32'd2, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'd0, 32'd2};
  logic        sg_s [5] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
  logic        sg_z [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
`ifdef DIV_SIGNED_EN
  logic [31:0] sg_q [5] = '{32'hFFFF_FFFD, 32'hFFFF_FFFD, 32'h8000_0000, 32'hFFFF_FFFF, 32'h7FFF_FFFC};
  logic [31:0] sg_r [5] = '{32'hFFFF_FFFF, 32'd1, 32'd0, 32'hFFFF_FFFB, 32'd1};
`else
  logic [31:0] sg_q [5] = '{32'h7FFF_FFFC, 32'd0, 32'd0, 32'hFFFF_FFFF, 32'h7FFF_FFFC};
  logic [31:0] sg_r [5] = '{32'd1, 32'd7, 32'h8000_0000, 32'hFFFF_FFFB, 32'd1};
`endif

  div_pipe_ctrl #(
    .DATA_W (32), .OPERS_PER_STAGE (8), .TAG_W (4), .FIFO_DEPTH (8)
  ) dut (
    .clk (clk), .rst_n (rst_n),
    .in_valid (in_valid), .in_ready (in_ready),
    .in_dividend (in_dividend), .in_divisor (in_divisor),
    .in_tag (in_tag), .in_signed (in_signed),
    .out_valid (out_valid), .out_ready (out_ready),
    .out_quotient (out_quotient), .out_remainder (out_remainder),
    .out_tag (out_tag), .out_div_by_zero (out_div_by_zero),
    .busy (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, req);
    end
  endtask

  // Called just after a negedge; returns just after the negedge following acceptance.
  task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic [3:0] tag,
                       input logic sgn, input logic [31:0] eq, input logic [31:0] er,
                       input logic edz, input logic lat, output int waited);
    exp_t e;
    in_valid = 1'b1; in_dividend = a; in_divisor = b; in_tag = tag; in_signed = sgn;
    waited = 0;
    while (!in_ready && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    if (!in_ready) begin
      checks++; failures++;
      $display("FAIL issue_timeout tag=%0d actual=not_accepted required=accepted", tag);
      in_valid = 1'b0;
    end else begin
      e.q = eq; e.r = er; e.tag = tag; e.dz = edz; e.lat = lat; e.acc = cyc + 1;
      exp_q.push_back(e);
      @(negedge clk);
      in_valid = 1'b0;
    end
  endtask

  task automatic wait_drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("drain_empty", exp_q.size(), 32'd0);
    repeat (2) @(negedge clk);
  endtask

  // out_ready changes away from the negedge where the monitor samples it.
  task automatic set_ready(input logic v);
    @(posedge clk);
    #1 out_ready = v;
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    int w;
    int stale;
    rst_n = 1'b0; in_valid = 1'b0; in_dividend = '0; in_divisor = '0;
    in_tag = '0; in_signed = 1'b0; out_ready = 1'b1;

    fork
      begin : monitor
        exp_t m;
        forever begin
          @(negedge clk);
          if (rst_n && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
              checks++; failures++;
              $display("FAIL unexpected_result actual q=%h tag=%0d required=no_output",
                       out_quotient, out_tag);
            end else begin
              m = exp_q.pop_front();
              chk("result_q", out_quotient, m.q);
              chk("result_r", out_remainder, m.r);
              chk("result_tag", 32'(out_tag), 32'(m.tag));
              chk("result_dz", 32'(out_div_by_zero), 32'(m.dz));
              if (m.lat) chk("latency", cyc - m.acc, 32'd5);
            end
          end
        end
      end
    join_none

    repeat (2) @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_quotient", out_quotient, 32'd0);
    chk("rst_remainder", out_remainder, 32'd0);
    chk("rst_tag", 32'(out_tag), 32'd0);
    chk("rst_dz", 32'(out_div_by_zero), 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    chk("ready_after_reset", 32'(in_ready), 32'd1);

    issue(32'd100, 32'd7, 4'd3, 1'b0, 32'd14, 32'd2, 1'b0, 1'b1, w);
    wait_drain();
    issue(32'h1234, 32'd0, 4'd9, 1'b0, 32'hFFFF_FFFF, 32'h1234, 1'b1, 1'b1, w);
    wait_drain();

    for (int i = 0; i < 8; i++) begin
      issue(b2b_a[i], b2b_b[i], 4'(i), 1'b0, b2b_q[i], b2b_r[i], b2b_z[i], 1'b1, w);
      chk("b2b_no_stall", w, 32'd0);
    end
    wait_drain();

    set_ready(1'b0);
    for (int i = 0; i < 8; i++) begin
      issue(bp_a[i], bp_b[i], 4'(i), 1'b0, bp_q[i], bp_r[i], 1'b0, 1'b0, w);
    end
    chk("bp_in_ready_low", 32'(in_ready), 32'd0);
    chk("bp_busy_high", 32'(busy), 32'd1);
    fork
      begin
        issue(bp_a[8], bp_b[8], 4'd8, 1'b0, bp_q[8], bp_r[8], 1'b0, 1'b0, w);
        issue(bp_a[9], bp_b[9], 4'd9, 1'b0, bp_q[9], bp_r[9], 1'b1, 1'b0, w);
      end
      begin
        repeat (6) @(negedge clk);
        set_ready(1'b1);
      end
    join
    wait_drain();
    chk("bp_busy_clear", 32'(busy), 32'd0);
    chk("bp_in_ready_back", 32'(in_ready), 32'd1);

    for (int i = 0; i < 5; i++) begin
      issue(sg_a[i], sg_b[i], 4'(10 + i), sg_s[i], sg_q[i], sg_r[i], sg_z[i], 1'b1, w);
      wait_drain();
    end

    set_ready(1'b0);
    for (int i = 0; i < 5; i++) begin
      issue(32'd50 + 32'(i), 32'd5, 4'(i), 1'b0, 32'd10, 32'(i), 1'b0, 1'b0, w);
    end
    repeat (2) @(negedge clk);
    chk("pre_reset_out_valid", 32'(out_valid), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_in_ready", 32'(in_ready), 32'd0);
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    set_ready(1'b1);
    stale = 0;
    repeat (20) begin
      @(negedge clk);
      if (out_valid) stale++;
    end
    chk("no_stale_after_reset", stale, 32'd0);
    chk("post_reset_busy", 32'(busy), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
